axil_master_arbiter: RTL and testbench

- Round-robin arbiter that shares one AXI-Lite master user interface between NUM_REQ requesters.
- The user interface is the wr_valid/wr_ready/wr_done and rd_valid/rd_ready/rd_done command port.
- Each requester issues unified read/write commands. The block serialises them with exactly one transaction in flight, and routes the completion back to the granted requester only.
- Sits between software/DMA-style clients and the AXI-Lite master wrapper.

---
 rtl/axil_master_arbiter_if.sv | 50 +++++
 rtl/axil_master_arbiter.sv | 116 +++++++++++
 tb/tb_axil_master_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_master_arbiter_if.sv
// Requester-side command/response bundle plus the AXI-Lite master user command port.
// The arbiter connects through the master modport; the environment uses the slave modport.
interface axil_master_arbiter_if #(
    parameter int NUM_REQ        = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
);
    localparam int GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                     req_valid;
    logic [NUM_REQ-1:0]                     req_ready;
    logic [NUM_REQ-1:0]                     req_write;
    logic [NUM_REQ-1:0][AXI_ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0][AXI_DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]                     rsp_done;
    logic [AXI_DATA_WIDTH-1:0]              rsp_rdata;
    logic [1:0]                             rsp_error;
    logic [GW-1:0]                          grant_id;
    logic                                   busy;

    logic                      wr_valid;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [AXI_DATA_WIDTH-1:0] wr_data;
    logic                      wr_ready;
    logic                      wr_done;
    logic [1:0]                wr_error;

    logic                      rd_valid;
    logic [AXI_ADDR_WIDTH-1:0] rd_addr;
    logic                      rd_ready;
    logic [AXI_DATA_WIDTH-1:0] rd_data;
    logic                      rd_done;
    logic [1:0]                rd_error;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  wr_ready, wr_done, wr_error,
        input  rd_ready, rd_data, rd_done, rd_error,
        output req_ready, rsp_done, rsp_rdata, rsp_error, grant_id, busy,
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output wr_ready, wr_done, wr_error,
        output rd_ready, rd_data, rd_done, rd_error,
        input  req_ready, rsp_done, rsp_rdata, rsp_error, grant_id, busy,
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr
    );
endinterface

// File: rtl/axil_master_arbiter.sv
// Shares one AXI-Lite master command port between NUM_REQ requesters, one transaction in flight.
// Define AXIL_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module axil_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    axil_master_arbiter_if.master bus
);
    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                    r_state, w_next;
    logic [GW-1:0]             r_last_grant, r_grant, w_sel;
    logic [GW:0]               w_idx;
    logic                      w_any, w_accept, w_hs, w_done, w_capture;
    logic                      r_write;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [AXI_DATA_WIDTH-1:0] r_wdata, r_rdata;
    logic [1:0]                r_error;

    always_comb begin
        w_sel = '0;
        w_any = 1'b0;
        w_idx = '0;
`ifdef AXIL_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_idx = (GW+1)'(i);
            if (bus.req_valid[w_idx[GW-1:0]]) begin
                w_sel = w_idx[GW-1:0];
                w_any = 1'b1;
            end
        end
`else
        // Scan starts just after the last owner and wraps, so the last owner is checked last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = {1'b0, r_last_grant} + (GW+1)'(k);
            if (w_idx >= (GW+1)'(NUM_REQ))
                w_idx = w_idx - (GW+1)'(NUM_REQ);
            if (!w_any && bus.req_valid[w_idx[GW-1:0]]) begin
                w_sel = w_idx[GW-1:0];
                w_any = 1'b1;
            end
        end
`endif
    end

    assign w_accept  = (r_state == S_IDLE) && w_any;
    assign w_hs      = r_write ? bus.wr_ready : bus.rd_ready;
    assign w_done    = r_write ? bus.wr_done  : bus.rd_done;
    assign w_capture = ((r_state == S_ISSUE) && w_hs && w_done) ||
                       ((r_state == S_WAIT) && w_done);

    always_ff @(posedge aclk) begin
        if (areset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ISSUE;
            S_ISSUE: if (w_hs)     w_next = w_done ? S_RESP : S_WAIT;
            S_WAIT:  if (w_done)   w_next = S_RESP;
            S_RESP:                w_next = S_IDLE;
            default:               w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_last_grant <= GW'(NUM_REQ - 1);
            r_grant      <= '0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_error      <= '0;
        end else begin
            if (w_accept) begin
                r_grant <= w_sel;
                r_write <= bus.req_write[w_sel];
                r_addr  <= bus.req_addr[w_sel];
                r_wdata <= bus.req_wdata[w_sel];
            end
            // Capture happens on the edge entering RESP, so the response holds until the next RESP.
            if (w_capture) begin
                r_rdata <= r_write ? '0 : bus.rd_data;
                r_error <= r_write ? bus.wr_error : bus.rd_error;
            end
            if (r_state == S_RESP)
                r_last_grant <= r_grant;
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (w_accept)
            bus.req_ready[w_sel] = 1'b1;
        bus.rsp_done = '0;
        if (r_state == S_RESP)
            bus.rsp_done[r_grant] = 1'b1;
        bus.rsp_rdata = r_rdata;
        bus.rsp_error = r_error;
        bus.grant_id  = r_grant;
        bus.busy      = (r_state != S_IDLE);
        bus.wr_valid  = (r_state == S_ISSUE) && r_write;
        bus.rd_valid  = (r_state == S_ISSUE) && !r_write;
        bus.wr_addr   = r_addr;
        bus.wr_data   = r_wdata;
        bus.rd_addr   = r_addr;
    end
endmodule

// File: tb/tb_axil_master_arbiter.sv
// Randomized and directed checks of axil_master_arbiter against a transaction-level model
// that tracks only the last owner and recomputes the winner from the arbitration rule.
module tb_axil_master_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic aclk;
    logic areset;
    int   n_chk;
    int   n_pass;
    int   last_grant_m;

    logic [N-1:0]  req_w;
    logic [AW-1:0] req_a [N];
    logic [DW-1:0] req_d [N];

    axil_master_arbiter_if #(.NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) bus ();

    axil_master_arbiter #(.NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic int model_pick(input logic [N-1:0] mask);
`ifdef AXIL_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++)
            if (mask[i]) return i;
`else
        for (int k = 1; k <= N; k++)
            if (mask[(last_grant_m + k) % N]) return (last_grant_m + k) % N;
`endif
        return -1;
    endfunction

    task automatic clear_inputs();
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.wr_ready  = 1'b0;
        bus.wr_done   = 1'b0;
        bus.wr_error  = 2'b00;
        bus.rd_ready  = 1'b0;
        bus.rd_data   = '0;
        bus.rd_done   = 1'b0;
        bus.rd_error  = 2'b00;
    endtask

    task automatic set_done(input logic wr, input logic [1:0] err, input logic [DW-1:0] rdat);
        if (wr) begin
            bus.wr_done  = 1'b1;
            bus.wr_error = err;
            bus.rd_data  = $urandom;
        end else begin
            bus.rd_done  = 1'b1;
            bus.rd_error = err;
            bus.rd_data  = rdat;
        end
    endtask

    task automatic apply_reset();
        bus.req_valid = '0;
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        last_grant_m = N - 1;
    endtask

    // Drives one whole transaction from the requester side and plays the AXI-Lite master.
    task automatic run_txn(input logic [N-1:0] mask, input int rdly, input int ddly,
                           input logic [1:0] err, input logic [DW-1:0] rdat,
                           input bit stray, output int granted);
        int          w;
        logic [N-1:0] exp_rdy;
        logic        wr;
        for (int i = 0; i < N; i++) begin
            bus.req_write[i] = req_w[i];
            bus.req_addr[i]  = req_a[i];
            bus.req_wdata[i] = req_d[i];
        end
        bus.req_valid = mask;
        #1;
        w = model_pick(mask);
        exp_rdy = '0;
        exp_rdy[w] = 1'b1;
        wr = req_w[w];
        n_chk++;
        if (bus.req_ready !== exp_rdy) $display("FAIL req_ready: got %b want %b", bus.req_ready, exp_rdy);
        else n_pass++;

        tick();
        bus.req_valid = mask & ~exp_rdy;
        #1;
        n_chk++;
        if (int'(bus.grant_id) !== w) $display("FAIL grant_id: got %0d want %0d", bus.grant_id, w);
        else n_pass++;
        n_chk++;
        if ({bus.wr_valid, bus.rd_valid} !== {wr, !wr})
            $display("FAIL issue_valid: got wr=%b rd=%b want wr=%b", bus.wr_valid, bus.rd_valid, wr);
        else n_pass++;
        for (int c = 0; c <= rdly; c++) begin
            if (c > 0) tick();
            n_chk++;
            if ((wr ? (bus.wr_valid !== 1'b1 || bus.wr_addr !== req_a[w] || bus.wr_data !== req_d[w])
                    : (bus.rd_valid !== 1'b1 || bus.rd_addr !== req_a[w])) || bus.req_ready !== '0)
                $display("FAIL issue_payload: cyc %0d wa=%h wd=%h ra=%h rdy=%b want addr=%h data=%h",
                         c, bus.wr_addr, bus.wr_data, bus.rd_addr, bus.req_ready, req_a[w], req_d[w]);
            else n_pass++;
        end

        if (wr) bus.wr_ready = 1'b1;
        else    bus.rd_ready = 1'b1;
        if (ddly == 0) set_done(wr, err, rdat);
        tick();
        bus.wr_ready = 1'b0;
        bus.rd_ready = 1'b0;
        bus.wr_done  = 1'b0;
        bus.rd_done  = 1'b0;
        for (int c = 1; c <= ddly; c++) begin
            #1;
            n_chk++;
            if (bus.wr_valid !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rsp_done !== '0)
                $display("FAIL wait_state: cyc %0d wr_valid=%b rd_valid=%b rsp_done=%b want 0",
                         c, bus.wr_valid, bus.rd_valid, bus.rsp_done);
            else n_pass++;
            if (c == ddly) set_done(wr, err, rdat);
            else if (stray && c == 1) set_done(!wr, ~err, ~rdat);
            tick();
            bus.wr_done = 1'b0;
            bus.rd_done = 1'b0;
        end

        #1;
        n_chk++;
        if (bus.rsp_done !== exp_rdy) $display("FAIL rsp_done: got %b want %b", bus.rsp_done, exp_rdy);
        else n_pass++;
        n_chk++;
        if (bus.rsp_rdata !== (wr ? '0 : rdat) || bus.rsp_error !== err)
            $display("FAIL rsp_payload: got rdata=%h err=%b want rdata=%h err=%b",
                     bus.rsp_rdata, bus.rsp_error, (wr ? '0 : rdat), err);
        else n_pass++;
        tick();
        n_chk++;
        if (bus.rsp_done !== '0 || bus.busy !== 1'b0)
            $display("FAIL rsp_end: got rsp_done=%b busy=%b want 0/0", bus.rsp_done, bus.busy);
        else n_pass++;
        last_grant_m = w;
        granted = w;
    endtask

    task automatic test_reset();
        clear_inputs();
        apply_reset();
        n_chk++;
        if (bus.req_ready !== '0 || bus.rsp_done !== '0 || bus.busy !== 1'b0)
            $display("FAIL reset_ctrl: got rdy=%b done=%b busy=%b want 0", bus.req_ready, bus.rsp_done, bus.busy);
        else n_pass++;
        n_chk++;
        if (bus.rsp_rdata !== '0 || bus.rsp_error !== 2'b00 || bus.grant_id !== '0)
            $display("FAIL reset_rsp: got rdata=%h err=%b gid=%0d want 0", bus.rsp_rdata, bus.rsp_error, bus.grant_id);
        else n_pass++;
        n_chk++;
        if (bus.wr_valid !== 1'b0 || bus.rd_valid !== 1'b0 || bus.wr_addr !== '0 ||
            bus.wr_data !== '0 || bus.rd_addr !== '0)
            $display("FAIL reset_axil: got wv=%b rv=%b wa=%h wd=%h ra=%h want 0",
                     bus.wr_valid, bus.rd_valid, bus.wr_addr, bus.wr_data, bus.rd_addr);
        else n_pass++;
    endtask

    task automatic test_single_write();
        int g;
        req_w[0] = 1'b1;
        req_a[0] = 32'h0000_0010;
        req_d[0] = 32'hDEAD_BEEF;
        run_txn(4'b0001, 0, 2, 2'b00, 32'h0, 1'b0, g);
        n_chk++;
        if (g !== 0) $display("FAIL single_write_owner: got %0d want 0", g);
        else n_pass++;
    endtask

    task automatic test_read_error();
        int g;
        req_w[2] = 1'b0;
        req_a[2] = 32'h0000_0020;
        req_d[2] = 32'h0;
        run_txn(4'b0100, 1, 1, 2'b10, 32'h1234_5678, 1'b0, g);
        n_chk++;
        if (g !== 2) $display("FAIL read_error_owner: got %0d want 2", g);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int g;
        int exp_order [5];
`ifdef AXIL_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        apply_reset();
        for (int i = 0; i < N; i++) begin
            req_w[i] = i[0];
            req_a[i] = 32'h100 + 32'(i * 4);
            req_d[i] = 32'hA000_0000 + 32'(i);
        end
        for (int t = 0; t < 5; t++) begin
            run_txn(4'b1111, 0, 1, 2'b00, 32'h5000_0000 + 32'(t), 1'b0, g);
            n_chk++;
            if (g !== exp_order[t]) $display("FAIL rr_order: txn %0d got %0d want %0d", t, g, exp_order[t]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int g;
        req_w = 4'b1111;
        for (int i = 0; i < N; i++) begin
            req_a[i] = 32'h0000_0200 + 32'(i * 8);
            req_d[i] = 32'hCAFE_0000 + 32'(i);
        end
        run_txn(4'b1111, 5, 2, 2'b01, 32'h0, 1'b0, g);
    endtask

    task automatic test_same_cycle_done();
        int g;
        req_w = 4'b1111;
        run_txn(4'b0010, 0, 0, 2'b11, 32'h0, 1'b0, g);
    endtask

    task automatic test_reset_mid_wait();
        int g;
        bus.req_write[0] = 1'b1;
        bus.req_addr[0]  = 32'h0000_0040;
        bus.req_wdata[0] = 32'h5555_AAAA;
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = '0;
        bus.wr_ready = 1'b1;
        tick();
        bus.wr_ready = 1'b0;
        #1;
        n_chk++;
        if (bus.busy !== 1'b1 || bus.wr_valid !== 1'b0)
            $display("FAIL mid_wait_entry: got busy=%b wr_valid=%b want 1/0", bus.busy, bus.wr_valid);
        else n_pass++;
        areset = 1'b1;
        tick();
        areset = 1'b0;
        last_grant_m = N - 1;
        n_chk++;
        if (bus.busy !== 1'b0 || bus.wr_valid !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rsp_done !== '0 ||
            bus.grant_id !== '0 || bus.rsp_error !== 2'b00 || bus.rsp_rdata !== '0 || bus.wr_addr !== '0)
            $display("FAIL mid_wait_reset: got busy=%b wv=%b rv=%b done=%b gid=%0d err=%b rdata=%h wa=%h want 0",
                     bus.busy, bus.wr_valid, bus.rd_valid, bus.rsp_done, bus.grant_id,
                     bus.rsp_error, bus.rsp_rdata, bus.wr_addr);
        else n_pass++;
        bus.rd_done = 1'b1;
        bus.wr_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        bus.wr_done = 1'b0;
        n_chk++;
        if (bus.rsp_done !== '0 || bus.busy !== 1'b0)
            $display("FAIL stray_done: got rsp_done=%b busy=%b want 0/0", bus.rsp_done, bus.busy);
        else n_pass++;
        run_txn(4'b1111, 0, 1, 2'b00, 32'h0BAD_F00D, 1'b0, g);
        n_chk++;
        if (g !== 0) $display("FAIL post_reset_owner: got %0d want 0", g);
        else n_pass++;
    endtask

    task automatic test_random();
        int g;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                req_w[i] = 1'($urandom_range(0, 1));
                req_a[i] = $urandom;
                req_d[i] = $urandom;
            end
            run_txn(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                    2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)), g);
        end
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        areset = 1'b1;
        last_grant_m = N - 1;
        req_w = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i] = '0;
            req_d[i] = '0;
        end
        test_reset();
        test_single_write();
        test_read_error();
        test_round_robin();
        test_backpressure();
        test_same_cycle_done();
        test_reset_mid_wait();
        test_random();
        bus.req_valid = '0;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
